// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Hazard-status inputs and pipeline-register controls exchanged
//               between the pipeline datapath and the stall/flush sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if;
    logic [4:0] i_id_rs1;
    logic [4:0] i_id_rs2;
    logic       i_id_uses_rs1;
    logic       i_id_uses_rs2;
    logic       i_ex_valid;
    logic [4:0] i_ex_rd;
    logic       i_ex_is_load;
    logic       i_ex_redirect;
    logic       i_trap_take;
    logic       i_ex_wfi;
    logic       i_irq_pending;
    logic       i_mem_busy;

    logic       o_pc_stall;
    logic       o_ifid_stall;
    logic       o_ifid_flush;
    logic       o_idex_stall;
    logic       o_idex_flush;
    logic       o_exmem_stall;
    logic       o_exmem_flush;
    logic       o_sleeping;

    // Datapath side: reports hazards, consumes register controls
    modport master (
        output i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
        output i_ex_valid, i_ex_rd, i_ex_is_load, i_ex_redirect,
        output i_trap_take, i_ex_wfi, i_irq_pending, i_mem_busy,
        input  o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall,
        input  o_idex_flush, o_exmem_stall, o_exmem_flush, o_sleeping
    );

    // Sequencer side
    modport slave (
        input  i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
        input  i_ex_valid, i_ex_rd, i_ex_is_load, i_ex_redirect,
        input  i_trap_take, i_ex_wfi, i_irq_pending, i_mem_busy,
        output o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall,
        output o_idex_flush, o_exmem_stall, o_exmem_flush, o_sleeping
    );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush sequencer for the five-stage pipeline: load-use,
//               redirects, traps, memory back-pressure and WFI sleep/wake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int WAKE_DELAY = 2
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst_n,
    pipe_hazard_ctrl_if.slave  hz_if
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    localparam logic [3:0] c_wake_load = 4'(WAKE_DELAY - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_wake_cnt;
    logic [3:0] w_wake_cnt_nxt;
    logic       w_hz;

    assign w_hz = hz_if.i_ex_valid & hz_if.i_ex_is_load & (hz_if.i_ex_rd != 5'd0) &
                  ((hz_if.i_id_uses_rs1 & (hz_if.i_id_rs1 == hz_if.i_ex_rd)) |
                   (hz_if.i_id_uses_rs2 & (hz_if.i_id_rs2 == hz_if.i_ex_rd)));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_RUN;
            r_wake_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wake_cnt <= w_wake_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wake_cnt_nxt = r_wake_cnt;
        if (hz_if.i_trap_take) begin
            w_state_nxt    = ST_RUN;
            w_wake_cnt_nxt = 4'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (hz_if.i_ex_valid & hz_if.i_ex_wfi & !hz_if.i_ex_redirect)
                        w_state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!hz_if.i_mem_busy)
                        w_state_nxt = ST_SLEEP;
                end
                ST_SLEEP: begin
                    if (hz_if.i_irq_pending) begin
                        w_state_nxt    = ST_WAKE;
                        w_wake_cnt_nxt = c_wake_load;
                    end
                end
                ST_WAKE: begin
                    if (r_wake_cnt == 4'd0)
                        w_state_nxt = ST_RUN;
                    else
                        w_wake_cnt_nxt = r_wake_cnt - 4'd1;
                end
                default: begin
                    w_state_nxt    = ST_RUN;
                    w_wake_cnt_nxt = 4'd0;
                end
            endcase
        end
    end

    // A trap overrides every state; each branch keeps flush and stall disjoint per register
    always_comb begin
        hz_if.o_pc_stall    = 1'b0;
        hz_if.o_ifid_stall  = 1'b0;
        hz_if.o_ifid_flush  = 1'b0;
        hz_if.o_idex_stall  = 1'b0;
        hz_if.o_idex_flush  = 1'b0;
        hz_if.o_exmem_stall = 1'b0;
        hz_if.o_exmem_flush = 1'b0;
        hz_if.o_sleeping    = 1'b0;
        if (hz_if.i_trap_take) begin
            hz_if.o_ifid_flush  = 1'b1;
            hz_if.o_idex_flush  = 1'b1;
            hz_if.o_exmem_flush = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (hz_if.i_ex_redirect) begin
                        hz_if.o_ifid_flush = 1'b1;
                        hz_if.o_idex_flush = 1'b1;
                    end else if (hz_if.i_mem_busy) begin
                        hz_if.o_pc_stall    = 1'b1;
                        hz_if.o_ifid_stall  = 1'b1;
                        hz_if.o_idex_stall  = 1'b1;
                        hz_if.o_exmem_stall = 1'b1;
                    end else if (w_hz) begin
                        hz_if.o_pc_stall   = 1'b1;
                        hz_if.o_ifid_stall = 1'b1;
                        hz_if.o_idex_flush = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    hz_if.o_pc_stall    = 1'b1;
                    hz_if.o_ifid_stall  = 1'b1;
                    hz_if.o_idex_flush  = 1'b1;
                    hz_if.o_exmem_stall = hz_if.i_mem_busy;
                end
                ST_SLEEP, ST_WAKE: begin
                    hz_if.o_pc_stall    = 1'b1;
                    hz_if.o_ifid_stall  = 1'b1;
                    hz_if.o_idex_stall  = 1'b1;
                    hz_if.o_exmem_flush = 1'b1;
                    hz_if.o_sleeping    = (r_state == ST_SLEEP);
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed-vector bench for the pipeline stall/flush sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    // Output vector: {pc_st, ifid_st, ifid_fl, idex_st, idex_fl, exmem_st, exmem_fl, sleeping}
    localparam logic [7:0] c_idle   = 8'b0000_0000;
    localparam logic [7:0] c_lu     = 8'b1100_1000;
    localparam logic [7:0] c_redir  = 8'b0010_1000;
    localparam logic [7:0] c_trap   = 8'b0010_1010;
    localparam logic [7:0] c_busy   = 8'b1101_0100;
    localparam logic [7:0] c_drain  = 8'b1100_1000;
    localparam logic [7:0] c_drainb = 8'b1100_1100;
    localparam logic [7:0] c_sleep  = 8'b1101_0011;
    localparam logic [7:0] c_wake   = 8'b1101_0010;

    logic       clk;
    logic       rst_n;
    logic [7:0] w_obs;
    int         r_vectors;
    int         r_errors;

    pipe_hazard_ctrl_if u_if ();

    pipe_hazard_ctrl #(.WAKE_DELAY(2)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .hz_if   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign w_obs = {u_if.o_pc_stall, u_if.o_ifid_stall, u_if.o_ifid_flush, u_if.o_idex_stall,
                    u_if.o_idex_flush, u_if.o_exmem_stall, u_if.o_exmem_flush, u_if.o_sleeping};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        r_vectors++;
        if (obs !== exp) begin
            r_errors++;
            $display("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        u_if.i_id_rs1      = 5'd0;
        u_if.i_id_rs2      = 5'd0;
        u_if.i_id_uses_rs1 = 1'b0;
        u_if.i_id_uses_rs2 = 1'b0;
        u_if.i_ex_valid    = 1'b0;
        u_if.i_ex_rd       = 5'd0;
        u_if.i_ex_is_load  = 1'b0;
        u_if.i_ex_redirect = 1'b0;
        u_if.i_trap_take   = 1'b0;
        u_if.i_ex_wfi      = 1'b0;
        u_if.i_irq_pending = 1'b0;
        u_if.i_mem_busy    = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2);
        u_if.i_ex_valid    = 1'b1;
        u_if.i_ex_is_load  = 1'b1;
        u_if.i_ex_rd       = rd;
        u_if.i_id_rs1      = rs1;
        u_if.i_id_rs2      = rs2;
        u_if.i_id_uses_rs1 = u1;
        u_if.i_id_uses_rs2 = u2;
    endtask

    // From RUN: present a WFI for one cycle and land in DRAIN with inputs cleared
    task automatic enter_drain();
        clear_inputs();
        u_if.i_ex_valid = 1'b1;
        u_if.i_ex_wfi   = 1'b1;
        tick();
        clear_inputs();
    endtask

    initial begin
        r_vectors = 0;
        r_errors  = 0;
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        #1 chk("reset", w_obs, c_idle);
        rst_n = 1'b1;
        tick();
        #1 chk("run_idle", w_obs, c_idle);

        // Load-use via rs1, then the bubble reaches EX
        set_load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        #1 chk("lu_rs1", w_obs, c_lu);
        tick();
        u_if.i_ex_valid = 1'b0;
        #1 chk("lu_bubble", w_obs, c_idle);
        set_load_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        #1 chk("lu_rd0", w_obs, c_idle);
        set_load_use(5'd7, 5'd3, 5'd7, 1'b1, 1'b1);
        #1 chk("lu_rs2", w_obs, c_lu);
        set_load_use(5'd9, 5'd9, 5'd1, 1'b0, 1'b0);
        #1 chk("lu_unused", w_obs, c_idle);
        u_if.i_ex_is_load = 1'b0;
        u_if.i_id_uses_rs1 = 1'b1;
        #1 chk("lu_not_load", w_obs, c_idle);

        // Priority: redirect > busy > hazard, trap above all
        set_load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        u_if.i_mem_busy    = 1'b1;
        u_if.i_ex_redirect = 1'b1;
        #1 chk("pri_redir", w_obs, c_redir);
        u_if.i_ex_redirect = 1'b0;
        #1 chk("pri_busy", w_obs, c_busy);
        u_if.i_trap_take = 1'b1;
        #1 chk("pri_trap", w_obs, c_trap);
        u_if.i_trap_take = 1'b0;
        u_if.i_mem_busy  = 1'b0;
        #1 chk("pri_hz", w_obs, c_lu);
        tick();
        clear_inputs();

        // Redirect in the same cycle as WFI suppresses sleep entry
        u_if.i_ex_valid    = 1'b1;
        u_if.i_ex_wfi      = 1'b1;
        u_if.i_ex_redirect = 1'b1;
        tick();
        clear_inputs();
        #1 chk("wfi_redir_stays_run", w_obs, c_idle);

        // WFI, memory idle: DRAIN one cycle, SLEEP, wake after WAKE_DELAY
        u_if.i_ex_valid = 1'b1;
        u_if.i_ex_wfi   = 1'b1;
        #1 chk("wfi_run_cycle", w_obs, c_idle);
        tick();
        clear_inputs();
        #1 chk("drain", w_obs, c_drain);
        tick();
        #1 chk("sleep1", w_obs, c_sleep);
        tick();
        #1 chk("sleep2", w_obs, c_sleep);
        u_if.i_irq_pending = 1'b1;
        #1 chk("sleep_irq", w_obs, c_sleep);
        tick();
        #1 chk("wake1", w_obs, c_wake);
        tick();
        u_if.i_ex_redirect = 1'b1;
        #1 chk("wake2_redir_ignored", w_obs, c_wake);
        tick();
        clear_inputs();
        #1 chk("run_after_wake", w_obs, c_idle);

        // WFI with memory busy three cycles, irq pulse in DRAIN is dropped
        enter_drain();
        u_if.i_mem_busy = 1'b1;
        #1 chk("drain_busy1", w_obs, c_drainb);
        tick();
        #1 chk("drain_busy2", w_obs, c_drainb);
        tick();
        #1 chk("drain_busy3", w_obs, c_drainb);
        tick();
        u_if.i_mem_busy    = 1'b0;
        u_if.i_irq_pending = 1'b1;
        #1 chk("drain_free", w_obs, c_drain);
        tick();
        u_if.i_irq_pending = 1'b0;
        #1 chk("sleep_after_busy", w_obs, c_sleep);
        tick();
        #1 chk("irq_pulse_not_latched", w_obs, c_sleep);
        u_if.i_trap_take = 1'b1;
        #1 chk("trap_in_sleep", w_obs, c_trap);
        tick();
        clear_inputs();
        #1 chk("run_after_trap_sleep", w_obs, c_idle);

        // irq already pending on SLEEP entry, then trap in WAKE
        enter_drain();
        u_if.i_irq_pending = 1'b1;
        #1 chk("drain_irq_held", w_obs, c_drain);
        tick();
        #1 chk("sleep_one_cycle", w_obs, c_sleep);
        tick();
        #1 chk("wake_after_one", w_obs, c_wake);
        u_if.i_trap_take = 1'b1;
        #1 chk("trap_in_wake", w_obs, c_trap);
        tick();
        clear_inputs();
        #1 chk("run_after_trap_wake", w_obs, c_idle);
        tick();
        #1 chk("run_stays", w_obs, c_idle);

        // Reset in SLEEP only takes effect at the edge
        enter_drain();
        tick();
        #1 chk("sleep_pre_reset", w_obs, c_sleep);
        rst_n = 1'b0;
        #1 chk("reset_between_edges", w_obs, c_sleep);
        tick();
        rst_n = 1'b1;
        #1 chk("reset_from_sleep", w_obs, c_idle);
        tick();
        #1 chk("run_after_reset", w_obs, c_idle);

        $display("== %0d vectors applied, %0d miscompares ==", r_vectors, r_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the cotm32 five-stage pipeline. It drives the stall and flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC stall. It resolves load-use hazards, control redirects, trap entry/exit, data-memory back-pressure and the WFI sleep/wake sequence. It sits beside the pipeline registers in the CPU top and owns the only WFI state machine in the core.

## Interface
- WAKE_DELAY, default 2: cycles the pipeline stays frozen after an interrupt wakes the core (1..15).
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  synchronous reset, active low.
- i_id_rs1, i_id_rs2  in  5 each  source register indices of the instruction in ID.
- i_id_uses_rs1, i_id_uses_rs2  in  1 each  the ID instruction actually reads that source.
- i_ex_valid  in  1  the EX stage holds a valid instruction (the ID/EX valid output).
- i_ex_rd  in  5  destination register of the EX instruction.
- i_ex_is_load  in  1  the EX instruction is a load (lsu_ls_op is a load).
- i_ex_redirect  in  1  a branch or jump is taken in EX.
- i_trap_take  in  1  trap entry or mret redirect is committing this cycle.
- i_ex_wfi  in  1  WFI request in EX (the ID/EX wfi output).
- i_irq_pending  in  1  an enabled interrupt is pending.
- i_mem_busy  in  1  the data memory cannot accept or complete the MEM access this cycle.
- o_pc_stall  out  1  hold the PC.
- o_ifid_stall, o_ifid_flush  out  1 each  IF/ID register controls.
- o_idex_stall, o_idex_flush  out  1 each  ID/EX register controls.
- o_exmem_stall, o_exmem_flush  out  1 each  EX/MEM register controls.
- o_sleeping  out  1  the core is in SLEEP (power-gating/debug hint).

## Operation
- Only the FSM state and the wake counter are registered. All outputs are combinational from state and the current inputs.
- States: RUN (encoding 0), DRAIN (1), SLEEP (2), WAKE (3).
- Load-use hazard (RUN only): `hz = i_ex_valid & i_ex_is_load & i_ex_rd != 0 & ((i_id_uses_rs1 & i_id_rs1 == i_ex_rd) | (i_id_uses_rs2 & i_id_rs2 == i_ex_rd))`.
- Output priority in RUN, highest first:
  1. `i_trap_take`: flush IF/ID, ID/EX and EX/MEM; no stalls.
  2. `i_ex_redirect`: flush IF/ID and ID/EX; no stalls.
  3. `i_mem_busy`: stall PC, IF/ID, ID/EX and EX/MEM; no flushes.
  4. `hz`: stall PC and IF/ID, flush ID/EX (insert a bubble).
  5. Otherwise all outputs are 0.
- A flush always overrides a stall on the same register. Never assert both on one register.
- RUN→DRAIN: `i_ex_valid & i_ex_wfi & !i_trap_take & !i_ex_redirect`. The WFI itself is allowed to advance into MEM on that cycle.
- DRAIN: stall PC and IF/ID, flush ID/EX. EX/MEM is stalled while `i_mem_busy`, otherwise not. Move to SLEEP when `!i_mem_busy`.
- SLEEP: stall PC, IF/ID and ID/EX; flush EX/MEM; `o_sleeping = 1`.
  - `i_irq_pending` moves to WAKE and loads the counter with WAKE_DELAY-1.
  - If `i_irq_pending` is already high on entry, SLEEP lasts exactly one cycle.
- WAKE: same outputs as SLEEP except `o_sleeping = 0`. Decrement the counter each cycle; at 0, go to RUN.
- `i_trap_take` in any state: next state is RUN and the counter clears. Outputs that cycle are the RUN trap outputs (all three flushes, no stalls).
- `i_ex_redirect`, `hz` and `i_ex_wfi` are ignored outside RUN.

## Timing
- Reset (`i_rst_n = 0` at a rising edge): state RUN, counter 0.
  - Output values while in reset follow RUN with inputs applied. The bench drives all inputs 0 during reset, so every output reads 0.
  - Reset mid-DRAIN, SLEEP or WAKE returns to RUN on the next edge with no wake delay.
- Load-use: stall/bubble lasts exactly 1 cycle per hazard. Next cycle the load is in MEM, `i_ex_valid` sees the bubble, and `hz` drops.
- Redirect/trap: flush for the single cycle the input is high; zero-cycle latency (combinational).
- WFI with memory idle: RUN(WFI seen) → DRAIN (1 cycle) → SLEEP.
- Wake latency from `i_irq_pending` rising in SLEEP to the first RUN cycle is 1 + WAKE_DELAY cycles.
- `i_irq_pending` pulses during DRAIN are not latched. Sleep entry continues, and the wake occurs only if the interrupt is still pending in SLEEP.
- Counter is 4 bits; no wrap. WAKE_DELAY = 1 means WAKE lasts one cycle.

## Test plan
- Load-use: EX = load, x5, valid; ID rs1 = 5, uses_rs1 = 1 → one cycle of pc_stall = ifid_stall = idex_flush = 1, then all 0. Repeat with rd = 0 → no stall.
- Priority: hz = 1, i_mem_busy = 1 and i_ex_redirect = 1 in the same cycle → ifid_flush = idex_flush = 1, all stalls 0. Drop redirect → four stalls = 1, idex_flush = 0.
- WFI sleep/wake, WAKE_DELAY = 2: WFI in EX with mem idle → DRAIN 1 cycle, then SLEEP with o_sleeping = 1. Raise irq → WAKE 2 cycles, RUN on the 3rd cycle after irq.
- WFI with i_mem_busy held 3 cycles → DRAIN lasts 3 cycles with exmem_stall = 1, then SLEEP.
- i_trap_take during SLEEP and during WAKE → all three flushes that cycle, state RUN next cycle, o_sleeping = 0.
- Reset asserted in SLEEP for 1 cycle with all inputs 0 → all outputs 0 and state RUN after release. Asynchronous assertion between edges has no effect until the edge.
